ldl_p1ram_arb: RTL and testbench

//  Initiator-side front end for a single-port RAM (re/we/addr/din, dout registered 1 cycle after re).

---
 rtl/ldl_p1ram_arb.sv | 133 +++++++++++++
 tb/tb_ldl_p1ram_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldl_p1ram_arb.sv
// Round-robin write/read front end for a single-port RAM with a 2-entry read response
// buffer; reads are credit-limited so response backpressure never drops data.
module ldl_p1ram_arb #(
    parameter int DW    = 8,
    parameter int DEPTH = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_valid,
    output logic          o_rd_ready,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] o_rsp_data,
    output logic          o_rsp_err,
    output logic          o_ram_re,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_din,
    input  logic [DW-1:0] i_ram_dout
);

    typedef enum logic {PRI_RD = 1'b0, PRI_WR = 1'b1} pri_t;

    localparam logic [AW:0] LP_DEPTH = DEPTH[AW:0];

    pri_t          r_pri;
    pri_t          w_pri_nxt;
    logic [1:0]    r_count;
    logic          r_head;
    logic          r_tail;
    logic          r_inflight;
    logic          r_infl_err;
    logic [AW-1:0] r_addr_hold;
    logic [DW-1:0] r_buf_data [2];
    logic          r_buf_err  [2];

    logic          w_wr_inrange;
    logic          w_rd_inrange;
    logic          w_wr_elig;
    logic          w_rd_elig;
    logic          w_wr_gnt;
    logic          w_rd_gnt;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_occ;

    assign w_wr_inrange = ({1'b0, i_wr_addr} < LP_DEPTH);
    assign w_rd_inrange = ({1'b0, i_rd_addr} < LP_DEPTH);

    assign w_push = r_inflight;
    assign w_pop  = o_rsp_valid && i_rsp_ready;

    // A slot freed by this cycle's pop is reusable, which is what sustains one read per cycle.
    assign w_occ     = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_rd_elig = i_rd_valid && (w_occ < 2'd2) && !i_rst;
    assign w_wr_elig = i_wr_valid && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pri <= PRI_RD;
        end else begin
            r_pri <= w_pri_nxt;
        end
    end

    always_comb begin
        w_wr_gnt  = 1'b0;
        w_rd_gnt  = 1'b0;
        w_pri_nxt = r_pri;
        if (w_rd_elig && w_wr_elig) begin
            if (r_pri == PRI_RD) begin
                w_rd_gnt  = 1'b1;
                w_pri_nxt = PRI_WR;
            end else begin
                w_wr_gnt  = 1'b1;
                w_pri_nxt = PRI_RD;
            end
        end else begin
            w_rd_gnt = w_rd_elig;
            w_wr_gnt = w_wr_elig;
        end
    end

    assign o_wr_ready = w_wr_gnt;
    assign o_rd_ready = w_rd_gnt;
    assign o_ram_we   = w_wr_gnt && w_wr_inrange;
    assign o_ram_re   = w_rd_gnt && w_rd_inrange;
    assign o_ram_din  = i_wr_data;
    assign o_ram_addr = w_rd_gnt ? i_rd_addr : (w_wr_gnt ? i_wr_addr : r_addr_hold);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count     <= 2'd0;
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_inflight  <= 1'b0;
            r_infl_err  <= 1'b0;
            r_addr_hold <= '0;
        end else begin
            r_inflight <= w_rd_gnt;
            r_infl_err <= w_rd_gnt && !w_rd_inrange;
            if (w_rd_gnt || w_wr_gnt) begin
                r_addr_hold <= o_ram_addr;
            end
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Storage needs no reset: entries are only observed while r_count says they are valid.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_buf_data[r_tail] <= r_infl_err ? '0 : i_ram_dout;
            r_buf_err[r_tail]  <= r_infl_err;
        end
    end

    assign o_rsp_valid = (r_count != 2'd0);
    assign o_rsp_data  = o_rsp_valid ? r_buf_data[r_head] : '0;
    assign o_rsp_err   = o_rsp_valid && r_buf_err[r_head];

endmodule

// File: tb/tb_ldl_p1ram_arb.sv
// Bench for ldl_p1ram_arb: behavioural RAM, response scoreboard, grant vector table and
// hand-written latency/backpressure/reset/throughput sequences.
module tb_ldl_p1ram_arb;
    localparam int DW    = 8;
    localparam int DEPTH = 10;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [AW-1:0] wr_addr, rd_addr, ram_addr;
    logic [DW-1:0] wr_data, rsp_data, ram_din, ram_dout;
    logic          rsp_valid, rsp_ready, rsp_err, ram_re, ram_we;

    always #5 clk = ~clk;

    ldl_p1ram_arb #(.DW(DW), .DEPTH(DEPTH)) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_valid (wr_valid),
        .o_wr_ready (wr_ready),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_rd_valid (rd_valid),
        .o_rd_ready (rd_ready),
        .i_rd_addr  (rd_addr),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_rsp_data (rsp_data),
        .o_rsp_err  (rsp_err),
        .o_ram_re   (ram_re),
        .o_ram_we   (ram_we),
        .o_ram_addr (ram_addr),
        .o_ram_din  (ram_din),
        .i_ram_dout (ram_dout)
    );

    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] shadow  [DEPTH];

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= ram_mem[ram_addr];
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_rsp   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    rsp_t          exp_q[$];
    rsp_t          exp_e;
    rsp_t          got_e;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d;
    logic          hold_e;

    // Scoreboard: expectations pushed on read acceptance, popped on response handshake.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            check("ram_re_we_excl", 32'(ram_re & ram_we), 32'd0);
            if (hold_v) begin
                check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                check("rsp_hold_data", 32'({rsp_err, rsp_data}), 32'({hold_e, hold_d}));
            end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rsp_unexpected: got data 0x%0h err %0b, expected no response",
                             rsp_data, rsp_err);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (rsp_data === exp_e.data && rsp_err === exp_e.err) n_pass++;
                    else $display("FAIL rsp_data: got 0x%0h err %0b, expected 0x%0h err %0b",
                                  rsp_data, rsp_err, exp_e.data, exp_e.err);
                end
            end
            if (rd_valid && rd_ready) begin
                if (int'(rd_addr) < DEPTH) begin
                    got_e.data = shadow[rd_addr];
                    got_e.err  = 1'b0;
                end else begin
                    got_e.data = '0;
                    got_e.err  = 1'b1;
                end
                exp_q.push_back(got_e);
            end
            if (wr_valid && wr_ready && int'(wr_addr) < DEPTH) shadow[wr_addr] = wr_data;
            hold_v = rsp_valid && !rsp_ready;
            hold_d = rsp_data;
            hold_e = rsp_err;
        end
    end

    typedef struct {
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rv;
        logic [AW-1:0] ra;
        logic          e_wrdy;
        logic          e_rrdy;
        logic          e_we;
        logic          e_re;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    int idx;
    int rsp_base;
    logic [AW-1:0] t3_addr [4];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = DW'(8'h50 + i);
            shadow[i]  = DW'(8'h50 + i);
        end
        // wr | rd pattern with the grant each cycle should produce, starting from pri=READ
        vecs[0]  = '{1'b1, 4'd1,  8'h11, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 4'd2,  8'h22, 1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 4'd2,  8'h22, 1'b1, 4'd2,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 4'd3,  8'h33, 1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 4'd3,  8'h33, 1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'd15, 8'h77, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'd9,  8'hEE, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 4'd12, 8'hFF, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 4'd0,  8'h01, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0};
        t3_addr[0] = 4'd4; t3_addr[1] = 4'd5; t3_addr[2] = 4'd6; t3_addr[3] = 4'd7;

        // reset: requests pending but nothing may be granted
        rst = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
        wr_addr = 4'd1; rd_addr = 4'd1; wr_data = 8'h00;
        repeat (2) @(posedge clk);
        #4;
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_ready", 32'(rd_ready), 32'd0);
        check("rst_ram_we_re", 32'({ram_we, ram_re}), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        rst = 1'b0; idle();

        // write then read same address: response 3 cycles after the write
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
        #3;
        check("t1_wr_ready", 32'(wr_ready), 32'd1);
        check("t1_ram_we", 32'(ram_we), 32'd1);
        check("t1_ram_addr", 32'(ram_addr), 32'd3);
        check("t1_ram_din", 32'(ram_din), 32'hA5);
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd3;
        #3;
        check("t1_rd_ready", 32'(rd_ready), 32'd1);
        check("t1_ram_re", 32'(ram_re), 32'd1);
        tick();
        rd_valid = 1'b0;
        #3;
        check("t1_rsp_n2", 32'(rsp_valid), 32'd0);
        tick();
        #3;
        check("t1_rsp_n3_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_n3_data", 32'(rsp_data), 32'hA5);
        check("t1_rsp_n3_err", 32'(rsp_err), 32'd0);
        tick();
        repeat (2) tick();

        // grant table, including alternating R,W,R,W under contention and out-of-range ops
        for (int i = 0; i < 13; i++) begin
            wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rd_valid = vecs[i].rv; rd_addr = vecs[i].ra;
            #3;
            check($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].e_wrdy));
            check($sformatf("vec%0d_rd_ready", i), 32'(rd_ready), 32'(vecs[i].e_rrdy));
            check($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
            check($sformatf("vec%0d_ram_re", i), 32'(ram_re), 32'(vecs[i].e_re));
            if (vecs[i].e_rrdy)
                check($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].ra));
            else if (vecs[i].e_wrdy)
                check($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].wa));
            tick();
        end
        idle();
        repeat (4) tick();

        // out-of-range read: zero data tagged as error, two cycles after acceptance
        rd_valid = 1'b1; rd_addr = 4'd12;
        #3;
        check("t4_rd_ready", 32'(rd_ready), 32'd1);
        check("t4_ram_re", 32'(ram_re), 32'd0);
        tick();
        idle();
        tick();
        #3;
        check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t4_rsp_data", 32'(rsp_data), 32'd0);
        check("t4_rsp_err", 32'(rsp_err), 32'd1);
        tick();
        repeat (2) tick();

        // backpressure: only two reads accepted while responses are stalled
        rsp_base = n_rsp;
        rsp_ready = 1'b0; idx = 0;
        for (int c = 0; c < 5; c++) begin
            rd_valid = 1'b1; rd_addr = t3_addr[idx];
            #3;
            check($sformatf("t3_stall_rd_ready%0d", c), 32'(rd_ready), (c < 2) ? 32'd1 : 32'd0);
            if (rd_ready) idx++;
            tick();
        end
        #3;
        check("t3_stall_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            rd_valid = 1'b1; rd_addr = t3_addr[idx];
            #3;
            if (rd_ready) idx++;
            tick();
        end
        idle();
        check("t3_all_accepted", 32'(idx), 32'd4);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_rsp_count", 32'(n_rsp - rsp_base), 32'd4);
        repeat (2) tick();

        // reset the cycle after a read accept: its data must never appear
        wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 8'h5A;
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd5;
        #3;
        check("t5_rd_ready", 32'(rd_ready), 32'd1);
        tick();
        rst = 1'b1;
        #3;
        check("t5_rst_rd_ready", 32'(rd_ready), 32'd0);
        check("t5_rst_ram_re", 32'(ram_re), 32'd0);
        tick();
        rst = 1'b0; idle();
        for (int c = 0; c < 4; c++) begin
            #3;
            check($sformatf("t5_no_rsp%0d", c), 32'(rsp_valid), 32'd0);
            tick();
        end
        wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 8'hC3;
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd5;
        tick();
        idle();
        for (int c = 0; c < 10 && !rsp_valid; c++) tick();
        #3;
        check("t5_fresh_valid", 32'(rsp_valid), 32'd1);
        check("t5_fresh_data", 32'(rsp_data), 32'hC3);
        tick();
        repeat (2) tick();

        // throughput: 16 back-to-back reads, one response per cycle after 2-cycle fill
        rsp_base = n_rsp;
        for (int c = 0; c < 19; c++) begin
            rd_valid = (c < 16);
            rd_addr  = AW'(c % DEPTH);
            #3;
            if (c < 16) check($sformatf("t6_rd_ready%0d", c), 32'(rd_ready), 32'd1);
            check($sformatf("t6_rsp_valid%0d", c), 32'(rsp_valid),
                  (c >= 2 && c < 18) ? 32'd1 : 32'd0);
            tick();
        end
        idle();
        check("t6_rsp_count", 32'(n_rsp - rsp_base), 32'd16);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
